// File: rtl/cache_pkg.sv
// cache_pkg: shared trace op codes, player states, trace entry and cache policy encodings
package cache_pkg;
  localparam int DEF_ADDR_W = 48;
  localparam int DEF_OP_W = 8;
  localparam logic [7:0] OP_READ = 8'h72;
  localparam logic [7:0] OP_WRITE = 8'h77;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} player_state_t;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_OP_W-1:0] op;
  } trace_entry_t;
  typedef enum logic [1:0] {REPL_LRU, REPL_FIFO, REPL_RANDOM} replace_policy_t;
  typedef enum logic {WRITE_BACK, WRITE_THROUGH} write_policy_t;
  typedef enum logic [1:0] {INCL_NINE, INCL_INCLUSIVE, INCL_EXCLUSIVE} inclusion_t;
endpackage

// File: rtl/cache_trace_player_ram.sv
// trace_ram: single-port synchronous trace memory with a one-cycle registered read
module trace_ram #(
  parameter type T = cache_pkg::trace_entry_t,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic re,
  input  logic [IDX_W-1:0] addr,
  input  T wdata,
  output T rdata
);
  T mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/cache_trace_player.sv
// cache_trace_player: replays an on-chip trace into cache_engine with backpressure, looping and stats
module cache_trace_player import cache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W = DEF_OP_W,
  parameter int DEPTH = 100000,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = 32,
  parameter logic [OP_W-1:0] OP_READ = cache_pkg::OP_READ,
  parameter logic [OP_W-1:0] OP_WRITE = cache_pkg::OP_WRITE
) (
  input  logic clk,
  input  logic reset,
  input  logic load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [OP_W-1:0] load_op,
  input  logic [IDX_W:0] trace_len,
  input  logic [15:0] loop_count,
  input  logic start,
  input  logic abort,
  output logic req_valid,
  input  logic req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [OP_W-1:0] req_op,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] skipped_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [15:0] pass_cnt
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0] op;
  } entry_t;
  player_state_t state;
  logic [IDX_W-1:0] idx, nidx, ram_addr;
  logic [IDX_W:0] len;
  logic [15:0] loops;
  entry_t q;
  logic we, re, op_ok, fire, last;
  always_comb begin
    we = load_en && state == IDLE && 32'(load_idx) < DEPTH;
    op_ok = q.op == OP_READ || q.op == OP_WRITE;
    req_valid = state == PRESENT && op_ok;
    fire = req_valid && req_ready;
    last = ({1'b0, idx} + (IDX_W+1)'(1)) == len;
    nidx = last ? '0 : idx + 1'b1;
    re = state == FETCH || (fire && !last);
    ram_addr = we ? load_idx : (state == FETCH ? idx : nidx);
    req_addr = req_valid ? q.addr : '0;
    req_op = req_valid ? q.op : '0;
    busy = state == FETCH || state == PRESENT;
    done = state == DONE;
  end
  trace_ram #(.T(entry_t), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk(clk), .we(we), .re(re), .addr(ram_addr),
    .wdata('{addr: load_addr, op: load_op}), .rdata(q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      loops <= '0;
      issued_cnt <= '0;
      skipped_cnt <= '0;
      stall_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          issued_cnt <= '0;
          skipped_cnt <= '0;
          stall_cnt <= '0;
          pass_cnt <= '0;
          len <= trace_len;
          loops <= loop_count == '0 ? 16'd1 : loop_count;
          idx <= '0;
          state <= trace_len == '0 ? DONE : FETCH;
        end
        FETCH: state <= abort ? DONE : PRESENT;
        PRESENT: begin
          if (!op_ok || fire) begin
            if (!op_ok) skipped_cnt <= skipped_cnt + CNT_W'(skipped_cnt != '1);
            else issued_cnt <= issued_cnt + CNT_W'(issued_cnt != '1);
            idx <= nidx;
            if (last) pass_cnt <= pass_cnt + 16'(pass_cnt != '1);
            state <= (last && pass_cnt + 16'd1 == loops) ? DONE : (last || !op_ok) ? FETCH : PRESENT;
          end else stall_cnt <= stall_cnt + CNT_W'(stall_cnt != '1);
          if (abort) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_trace_player.sv
// tb_cache_trace_player: table-driven replay scenarios plus reset corner sequences
module tb_cache_trace_player;
  localparam int DEPTH = 12;
  localparam int IDX_W = $clog2(DEPTH);
  logic clk = 0, reset, load_en, start, abort, req_ready, req_valid, busy, done;
  logic [IDX_W-1:0] load_idx;
  logic [47:0] load_addr, req_addr;
  logic [7:0] load_op, req_op;
  logic [IDX_W:0] trace_len;
  logic [15:0] loop_count, pass_cnt;
  logic [31:0] issued_cnt, skipped_cnt, stall_cnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  cache_trace_player #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
    .load_op(load_op), .trace_len(trace_len), .loop_count(loop_count), .start(start),
    .abort(abort), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .busy(busy), .done(done), .issued_cnt(issued_cnt),
    .skipped_cnt(skipped_cnt), .stall_cnt(stall_cnt), .pass_cnt(pass_cnt)
  );
  typedef struct {
    logic [7:0] op1;
    int len, loops, stall, abort_at, issued, skipped, stalls, passes, done_cyc;
    logic [5:0][15:0] seq;
  } scn_t;
  scn_t t [7];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load(input int i, input logic [47:0] a, input logic [7:0] o);
    load_en = 1; load_idx = IDX_W'(i); load_addr = a; load_op = o;
    @(negedge clk);
    load_en = 0;
  endtask
  task automatic run(input int k, input scn_t s, input bit busy_load);
    int n, done_at, ndone, late, left;
    n = 0; done_at = -1; ndone = 0; late = 0; left = s.stall;
    load(1, 48'h2000, s.op1);
    trace_len = (IDX_W+1)'(s.len); loop_count = 16'(s.loops); start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 40; c++) begin
      req_ready = !(req_valid && req_addr == 48'h2000 && left > 0);
      if (!req_ready) left--;
      abort = req_valid && req_ready && n + 1 == s.abort_at;
      start = c == 3 && busy;
      load_en = busy_load && c == 3 && busy; load_idx = 0; load_addr = 48'h9000; load_op = 8'h72;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (req_valid) begin
        if (done_at >= 0) late++;
        else if (n >= 6) begin
          checks++; errors++;
          $display("FAIL extra_req scn%0d: got addr %0h expected none", k, req_addr);
        end else begin
          chk($sformatf("addr scn%0d #%0d", k, n), req_addr, {32'h0, s.seq[n]});
          chk($sformatf("op scn%0d #%0d", k, n), req_op, s.seq[n][12] ? 8'h72 : 8'h77);
        end
        if (req_ready) n++;
      end
      @(negedge clk);
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    start = 0; abort = 0; load_en = 0; req_ready = 1;
    chk($sformatf("done_cycle scn%0d", k), done_at, s.done_cyc);
    chk($sformatf("done_pulses scn%0d", k), ndone, 1);
    chk($sformatf("late_valid scn%0d", k), late, 0);
    chk($sformatf("fires scn%0d", k), n, s.issued);
    chk($sformatf("issued_cnt scn%0d", k), issued_cnt, s.issued);
    chk($sformatf("skipped_cnt scn%0d", k), skipped_cnt, s.skipped);
    chk($sformatf("stall_cnt scn%0d", k), stall_cnt, s.stalls);
    chk($sformatf("pass_cnt scn%0d", k), pass_cnt, s.passes);
    chk($sformatf("busy_after scn%0d", k), busy, 0);
  endtask
  initial begin
    t[0] = '{8'h77, 4, 1, 0, 0, 4, 0, 0, 1, 5, {16'h0, 16'h0, 16'h4000, 16'h3000, 16'h2000, 16'h1000}};
    t[1] = '{8'h77, 4, 1, 3, 0, 4, 0, 3, 1, 8, {16'h0, 16'h0, 16'h4000, 16'h3000, 16'h2000, 16'h1000}};
    t[2] = '{8'h00, 4, 1, 0, 0, 3, 1, 0, 1, 6, {16'h0, 16'h0, 16'h0, 16'h4000, 16'h3000, 16'h1000}};
    t[3] = '{8'h77, 2, 3, 0, 0, 6, 0, 0, 3, 9, {16'h2000, 16'h1000, 16'h2000, 16'h1000, 16'h2000, 16'h1000}};
    t[4] = '{8'h77, 2, 0, 0, 0, 2, 0, 0, 1, 3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h2000, 16'h1000}};
    t[5] = '{8'h77, 4, 1, 0, 2, 2, 0, 0, 0, 3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h2000, 16'h1000}};
    t[6] = '{8'h77, 0, 1, 0, 0, 0, 0, 0, 0, 0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    reset = 1; load_en = 0; start = 0; abort = 0; req_ready = 1;
    load_idx = 0; load_addr = 0; load_op = 0; trace_len = 0; loop_count = 0;
    repeat (2) @(negedge clk);
    chk("rst req_valid", req_valid, 0);
    chk("rst req_addr", req_addr, 0);
    chk("rst req_op", req_op, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst counters", issued_cnt | skipped_cnt | stall_cnt | 32'(pass_cnt), 0);
    reset = 0;
    load(0, 48'h1000, 8'h72);
    load(1, 48'h2000, 8'h77);
    load(2, 48'h3000, 8'h72);
    load(3, 48'h4000, 8'h77);
    load(13, 48'h5000, 8'h72);
    for (int k = 0; k < 7; k++) run(k, t[k], k == 0);
    load(1, 48'h2000, 8'h77);
    trace_len = 4; loop_count = 1; req_ready = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("mid req_valid", req_valid, 1);
    chk("mid stall_cnt", stall_cnt, 1);
    reset = 1;
    @(negedge clk);
    chk("post_rst req_valid", req_valid, 0);
    chk("post_rst busy", busy, 0);
    chk("post_rst stall_cnt", stall_cnt, 0);
    chk("post_rst issued_cnt", issued_cnt, 0);
    reset = 0; req_ready = 1;
    @(negedge clk);
    chk("idle req_valid", req_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
